// File: rtl/walk_register.sv
// Sticky pedestrian walk-request latch: holds a synchronized button request until the
// controller clears it, and counts distinct presses while the request is pending.
module walk_register #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WR_Sync,
    input  logic             WR_Reset,
    output logic             WR,
    output logic             WR_Press,
    output logic [CNT_W-1:0] WR_Count
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync_q;
    logic             rise;
    logic [CNT_W-1:0] count_next;

    assign rise = WR_Sync & ~sync_q;
    assign WR   = (state == PENDING);

    // The clear beats a same-cycle press; a level press alone is enough to set the request
    always_comb begin
        state_next = state;
        count_next = WR_Count;
        if (WR_Reset) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            if (WR_Sync) begin
                state_next = PENDING;
            end
            if (rise && (WR_Count != '1)) begin
                count_next = WR_Count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sync_q   <= 1'b0;
            WR_Press <= 1'b0;
            WR_Count <= '0;
        end else begin
            state    <= state_next;
            sync_q   <= WR_Sync;
            WR_Press <= rise;
            WR_Count <= count_next;
        end
    end

endmodule

// File: tb/tb_walk_register.sv
// Self-checking bench for walk_register: directed scenarios plus a random phase,
// every cycle compared against a behavioural model of the walk-request rules.
module tb_walk_register;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             WR_Sync;
    logic             WR_Reset;
    logic             WR;
    logic             WR_Press;
    logic [CNT_W-1:0] WR_Count;

    int checks;
    int passes;
    int press_seen;

    // Reference model state
    bit m_wr;
    bit m_press;
    int m_count;
    bit m_prev;

    walk_register #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .WR_Sync  (WR_Sync),
        .WR_Reset (WR_Reset),
        .WR       (WR),
        .WR_Press (WR_Press),
        .WR_Count (WR_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".WR"}, {31'd0, WR}, {31'd0, m_wr});
        checkValue({tag, ".WR_Press"}, {31'd0, WR_Press}, {31'd0, m_press});
        checkValue({tag, ".WR_Count"}, {{(32-CNT_W){1'b0}}, WR_Count}, m_count);
    endtask

    // Model of one clock edge, written straight from the behavioural rules
    task automatic modelEdge(input bit s, input bit clr, input bit r);
        bit rise_m;
        rise_m = s && !m_prev;
        if (r) begin
            m_wr    = 0;
            m_press = 0;
            m_count = 0;
            m_prev  = 0;
        end else begin
            m_press = rise_m;
            if (clr) begin
                m_wr    = 0;
                m_count = 0;
            end else begin
                if (s) m_wr = 1;
                if (rise_m) m_count = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
            end
            m_prev = s;
        end
    endtask

    task automatic applyStimulus(input string tag, input bit s, input bit clr, input bit r);
        @(negedge clk);
        WR_Sync  = s;
        WR_Reset = clr;
        rst      = r;
        @(posedge clk);
        modelEdge(s, clr, r);
        #1;
        checkOutput(tag);
        if (WR_Press === 1'b1) press_seen++;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        press_seen = 0;
        m_wr = 0; m_press = 0; m_count = 0; m_prev = 0;
        WR_Sync = 0; WR_Reset = 0; rst = 1;

        // Reset held with the button down, then released: a fresh rising edge
        applyStimulus("reset0", 1, 0, 1);
        applyStimulus("reset1", 1, 0, 1);
        checkValue("reset_wr", {31'd0, WR}, 32'd0);
        checkValue("reset_count", {28'd0, WR_Count}, 32'd0);
        press_seen = 0;
        applyStimulus("post_reset", 1, 0, 0);
        checkValue("post_reset_wr", {31'd0, WR}, 32'd1);
        checkValue("post_reset_count", {28'd0, WR_Count}, 32'd1);
        checkValue("post_reset_press", {31'd0, WR_Press}, 32'd1);
        applyStimulus("post_reset_rel", 0, 0, 0);
        checkValue("post_reset_press_once", press_seen, 32'd1);

        // Single press followed by a long hold
        applyStimulus("pre_clear", 0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus("idle", 0, 0, 0);
        press_seen = 0;
        applyStimulus("single_press", 1, 0, 0);
        for (int i = 0; i < 40; i++) applyStimulus("single_hold", 0, 0, 0);
        checkValue("single_wr", {31'd0, WR}, 32'd1);
        checkValue("single_count", {28'd0, WR_Count}, 32'd1);
        checkValue("single_pulses", press_seen, 32'd1);

        // Clear held high; presses during the clear are ignored
        applyStimulus("clear", 0, 1, 0);
        checkValue("clear_wr", {31'd0, WR}, 32'd0);
        checkValue("clear_count", {28'd0, WR_Count}, 32'd0);
        applyStimulus("clear_press", 1, 1, 0);
        applyStimulus("clear_press_rel", 0, 1, 0);
        checkValue("clear_hold_wr", {31'd0, WR}, 32'd0);
        applyStimulus("clear_release", 0, 0, 0);
        checkValue("clear_release_wr", {31'd0, WR}, 32'd0);

        // Level press still high when the clear drops sets the request without counting
        applyStimulus("level_under_clear", 1, 1, 0);
        applyStimulus("level_after_clear", 1, 0, 0);
        checkValue("level_wr", {31'd0, WR}, 32'd1);
        checkValue("level_count", {28'd0, WR_Count}, 32'd0);
        applyStimulus("level_release", 0, 1, 0);

        // Simultaneous set and clear from idle
        applyStimulus("simul", 1, 1, 0);
        checkValue("simul_wr", {31'd0, WR}, 32'd0);
        checkValue("simul_count", {28'd0, WR_Count}, 32'd0);
        checkValue("simul_press", {31'd0, WR_Press}, 32'd1);
        applyStimulus("simul_release", 0, 0, 0);

        // Twenty separated presses: counter saturates at all-ones
        press_seen = 0;
        for (int p = 1; p <= 20; p++) begin
            applyStimulus("sat_press", 1, 0, 0);
            applyStimulus("sat_gap", 0, 0, 0);
            if (p == 15) checkValue("sat_count_15", {28'd0, WR_Count}, 32'd15);
        end
        checkValue("sat_count_20", {28'd0, WR_Count}, 32'd15);
        checkValue("sat_wr", {31'd0, WR}, 32'd1);
        checkValue("sat_pulses", press_seen, 32'd20);

        // Long press: a single count and a single pulse
        applyStimulus("long_clear", 0, 1, 0);
        press_seen = 0;
        for (int i = 0; i < 8; i++) applyStimulus("long_press", 1, 0, 0);
        applyStimulus("long_release", 0, 0, 0);
        checkValue("long_count", {28'd0, WR_Count}, 32'd1);
        checkValue("long_pulses", press_seen, 32'd1);
        checkValue("long_wr", {31'd0, WR}, 32'd1);

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 99) < 40),
                          ($urandom_range(0, 99) < 8),
                          ($urandom_range(0, 99) < 2));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
